pipe_hazard_ctrl: RTL and testbench

//  Central pipeline sequencer for the 5-stage 8-bit datapath (IF, ID, EXE, MEM, WB).

---
 rtl/pipe_hazard_ctrl.sv | 128 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage 8-bit datapath: stage enables/flushes,
// load-use/branch hazards, data-memory handshake, timeout and stall counter.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       id_rs1,
  input  logic [2:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [2:0]       exe_rd,
  input  logic             exe_memRd,
  input  logic             exe_regWr,
  input  logic             br_taken,
  input  logic             mem_memRd,
  input  logic             mem_memWr,
  input  logic             dmem_ack,
  output logic             dmem_req,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idexe_en,
  output logic             idexe_flush,
  output logic             exemem_en,
  output logic             memwb_flush,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {StRun, StMemWait, StError} state_e;

  localparam logic [7:0] TimeoutVal = 8'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             memop;
  logic             load_use;

  assign memop    = mem_memRd | mem_memWr;
  assign load_use = exe_memRd & exe_regWr & (exe_rd != 3'd0) &
                    ((id_rs1_used & (id_rs1 == exe_rd)) |
                     (id_rs2_used & (id_rs2 == exe_rd)));

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    dmem_req    = 1'b0;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idexe_en    = 1'b0;
    idexe_flush = 1'b0;
    exemem_en   = 1'b0;
    memwb_flush = 1'b0;
    err         = 1'b0;
    if (rst) begin
      state_d = StRun;
      wait_d  = 8'd0;
    end else begin
      case (state_q)
        StRun: begin
          pc_en     = 1'b1;
          ifid_en   = 1'b1;
          idexe_en  = 1'b1;
          exemem_en = 1'b1;
          if (memop) begin
            dmem_req = 1'b1;
            if (!dmem_ack) begin
              pc_en       = 1'b0;
              ifid_en     = 1'b0;
              idexe_en    = 1'b0;
              exemem_en   = 1'b0;
              memwb_flush = 1'b1;
              wait_d      = 8'd1;
              state_d     = StMemWait;
            end
          end else if (br_taken) begin
            ifid_flush  = 1'b1;
            idexe_flush = 1'b1;
          end else if (load_use) begin
            // One bubble suffices: the load moves on to MEM next cycle.
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idexe_flush = 1'b1;
          end
        end
        StMemWait: begin
          dmem_req = 1'b1;
          if (dmem_ack) begin
            pc_en     = 1'b1;
            ifid_en   = 1'b1;
            idexe_en  = 1'b1;
            exemem_en = 1'b1;
            wait_d    = 8'd0;
            state_d   = StRun;
          end else begin
            memwb_flush = 1'b1;
            wait_d      = wait_q + 8'd1;
            if (wait_q == TimeoutVal) state_d = StError;
          end
        end
        StError: err = 1'b1;
        default: state_d = StRun;
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (rst) begin
      stall_d = '0;
    end else if (!pc_en && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    wait_q  <= wait_d;
    stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl; a second instance with a
// narrow counter and short timeout covers saturation.
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        rst, rst_s;
  logic [2:0]  id_rs1, id_rs2, exe_rd;
  logic        id_rs1_used, id_rs2_used, exe_memRd, exe_regWr, br_taken;
  logic        mem_memRd, mem_memWr, dmem_ack;

  logic        dmem_req, pc_en, ifid_en, ifid_flush, idexe_en, idexe_flush;
  logic        exemem_en, memwb_flush, err;
  logic [15:0] stall_cnt;

  logic        dmem_req_s, pc_en_s, ifid_en_s, ifid_flush_s, idexe_en_s, idexe_flush_s;
  logic        exemem_en_s, memwb_flush_s, err_s;
  logic [3:0]  stall_cnt_s;

  logic [8:0]  ctl, ctl_s;
  int          total = 0;
  int          bad   = 0;

  // {dmem_req, pc_en, ifid_en, ifid_flush, idexe_en, idexe_flush, exemem_en, memwb_flush, err}
  localparam logic [8:0] CtlRst    = 9'b0_0_0_0_0_0_0_0_0;
  localparam logic [8:0] CtlRun    = 9'b0_1_1_0_1_0_1_0_0;
  localparam logic [8:0] CtlLdUse  = 9'b0_0_0_0_1_1_1_0_0;
  localparam logic [8:0] CtlBranch = 9'b0_1_1_1_1_1_1_0_0;
  localparam logic [8:0] CtlFreeze = 9'b1_0_0_0_0_0_0_1_0;
  localparam logic [8:0] CtlAcked  = 9'b1_1_1_0_1_0_1_0_0;
  localparam logic [8:0] CtlError  = 9'b0_0_0_0_0_0_0_0_1;

  assign ctl   = {dmem_req, pc_en, ifid_en, ifid_flush, idexe_en, idexe_flush,
                  exemem_en, memwb_flush, err};
  assign ctl_s = {dmem_req_s, pc_en_s, ifid_en_s, ifid_flush_s, idexe_en_s, idexe_flush_s,
                  exemem_en_s, memwb_flush_s, err_s};

  pipe_hazard_ctrl u_dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .exe_rd(exe_rd),
    .exe_memRd(exe_memRd), .exe_regWr(exe_regWr), .br_taken(br_taken),
    .mem_memRd(mem_memRd), .mem_memWr(mem_memWr), .dmem_ack(dmem_ack),
    .dmem_req(dmem_req), .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idexe_en(idexe_en), .idexe_flush(idexe_flush), .exemem_en(exemem_en),
    .memwb_flush(memwb_flush), .err(err), .stall_cnt(stall_cnt)
  );

  pipe_hazard_ctrl #(.MEM_TIMEOUT(3), .CNT_W(4)) u_dut_s (
    .clk(clk), .rst(rst_s), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .exe_rd(exe_rd),
    .exe_memRd(exe_memRd), .exe_regWr(exe_regWr), .br_taken(br_taken),
    .mem_memRd(mem_memRd), .mem_memWr(mem_memWr), .dmem_ack(dmem_ack),
    .dmem_req(dmem_req_s), .pc_en(pc_en_s), .ifid_en(ifid_en_s), .ifid_flush(ifid_flush_s),
    .idexe_en(idexe_en_s), .idexe_flush(idexe_flush_s), .exemem_en(exemem_en_s),
    .memwb_flush(memwb_flush_s), .err(err_s), .stall_cnt(stall_cnt_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge; inputs change and outputs are sampled there.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    id_rs1 = 3'd0; id_rs2 = 3'd0; exe_rd = 3'd0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    exe_memRd = 1'b0; exe_regWr = 1'b0; br_taken = 1'b0;
    mem_memRd = 1'b0; mem_memWr = 1'b0; dmem_ack = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst   = 1'b1;
    rst_s = 1'b1;
    next_cycle(); #1;
    chk("rst_ctl", 32'(ctl), 32'(CtlRst));

    next_cycle(); rst = 1'b0; #1;
    chk("run_ctl", 32'(ctl), 32'(CtlRun));
    chk("run_cnt", 32'(stall_cnt), 32'd0);

    // Load-use on rs1
    next_cycle();
    exe_memRd = 1'b1; exe_regWr = 1'b1; exe_rd = 3'd3; id_rs1 = 3'd3; id_rs1_used = 1'b1; #1;
    chk("lu_rs1", 32'(ctl), 32'(CtlLdUse));
    next_cycle(); clear_inputs(); #1;
    chk("lu_after", 32'(ctl), 32'(CtlRun));
    chk("lu_cnt", 32'(stall_cnt), 32'd1);

    // Load-use on rs2
    next_cycle();
    exe_memRd = 1'b1; exe_regWr = 1'b1; exe_rd = 3'd5; id_rs2 = 3'd5; id_rs2_used = 1'b1; #1;
    chk("lu_rs2", 32'(ctl), 32'(CtlLdUse));

    // No hazard: r0 destination
    next_cycle(); clear_inputs();
    exe_memRd = 1'b1; exe_regWr = 1'b1; exe_rd = 3'd0; id_rs1 = 3'd0; id_rs1_used = 1'b1; #1;
    chk("lu_r0", 32'(ctl), 32'(CtlRun));
    chk("lu_cnt2", 32'(stall_cnt), 32'd2);

    // No hazard: source not used
    next_cycle();
    exe_rd = 3'd3; id_rs1 = 3'd3; id_rs1_used = 1'b0; #1;
    chk("lu_unused", 32'(ctl), 32'(CtlRun));

    // No hazard: EXE is not a load
    next_cycle();
    exe_memRd = 1'b0; id_rs1_used = 1'b1; #1;
    chk("lu_noload", 32'(ctl), 32'(CtlRun));

    // Branch wins over load-use
    next_cycle();
    exe_memRd = 1'b1; br_taken = 1'b1; #1;
    chk("br_lu", 32'(ctl), 32'(CtlBranch));
    next_cycle(); clear_inputs(); #1;
    chk("br_cnt", 32'(stall_cnt), 32'd2);

    // Store acked on the 4th cycle; branch during the wait is ignored
    mem_memWr = 1'b1; #1;
    chk("st_c1", 32'(ctl), 32'(CtlFreeze));
    next_cycle(); br_taken = 1'b1; #1;
    chk("st_c2", 32'(ctl), 32'(CtlFreeze));
    next_cycle(); #1;
    chk("st_c3", 32'(ctl), 32'(CtlFreeze));
    next_cycle(); dmem_ack = 1'b1; br_taken = 1'b0; #1;
    chk("st_ack", 32'(ctl), 32'(CtlAcked));
    next_cycle(); clear_inputs(); #1;
    chk("st_done", 32'(ctl), 32'(CtlRun));
    chk("st_cnt", 32'(stall_cnt), 32'd5);

    // Single-cycle load
    next_cycle(); mem_memRd = 1'b1; dmem_ack = 1'b1; #1;
    chk("ld_1cyc", 32'(ctl), 32'(CtlAcked));
    next_cycle(); clear_inputs(); #1;
    chk("ld_1cyc_cnt", 32'(stall_cnt), 32'd5);

    // Load never acked: 16 frozen cycles then ERROR
    mem_memRd = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("to_frz", 32'(ctl), 32'(CtlFreeze));
      next_cycle();
    end
    #1;
    chk("to_err", 32'(ctl), 32'(CtlError));
    chk("to_cnt", 32'(stall_cnt), 32'd21);
    next_cycle(); mem_memRd = 1'b0; dmem_ack = 1'b1; #1;
    chk("to_sticky", 32'(ctl), 32'(CtlError));
    chk("to_cnt2", 32'(stall_cnt), 32'd22);
    next_cycle(); rst = 1'b1; #1;
    chk("to_rst", 32'(ctl), 32'(CtlRst));
    next_cycle(); rst = 1'b0; dmem_ack = 1'b0; #1;
    chk("to_rec", 32'(ctl), 32'(CtlRun));
    chk("to_rec_cnt", 32'(stall_cnt), 32'd0);

    // Reset in the middle of a memory wait
    next_cycle(); mem_memRd = 1'b1; #1;
    chk("mr_frz", 32'(ctl), 32'(CtlFreeze));
    next_cycle(); rst = 1'b1; #1;
    chk("mr_req", 32'(dmem_req), 32'd0);
    next_cycle(); rst = 1'b0; mem_memRd = 1'b0; #1;
    chk("mr_run", 32'(ctl), 32'(CtlRun));
    chk("mr_cnt", 32'(stall_cnt), 32'd0);

    // Narrow instance: timeout 3 -> ERROR after 4 frozen cycles, counter saturates at 15
    next_cycle(); rst_s = 1'b0; mem_memRd = 1'b1; #1;
    chk("sat_frz", 32'(ctl_s), 32'(CtlFreeze));
    for (int i = 0; i < 4; i++) next_cycle();
    #1;
    chk("sat_err", 32'(ctl_s), 32'(CtlError));
    chk("sat_cnt4", 32'(stall_cnt_s), 32'd4);
    for (int i = 0; i < 20; i++) next_cycle();
    #1;
    chk("sat_cnt", 32'(stall_cnt_s), 32'd15);
    chk("sat_errs", 32'(err_s), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
